sha256_compress_rounds: RTL and testbench
=========================================

SHA256_COMPRESS_ROUNDS -- requirements
Module: sha256_compress_rounds

Interface
REQ-001 Parameter W_LENGTH, default 64: number of schedule words consumed, and the number of rounds executed.
REQ-002 Port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port start, input, 1: request to compress one block; sampled only in IDLE.
REQ-005 Port w_vector_complete, input, 1: indicates that the schedule producer's w_vector holds all W_LENGTH expanded words.
REQ-006 Port w_vector, input, 32*W_LENGTH: schedule word i occupies bits [32i+31:32i].
REQ-007 Port hash_in, input, 256: chaining value H0..H7, with H0 at [255:224] and H7 at [31:0].
REQ-008 Port busy, output, 1: high while a block is being processed.
REQ-009 Port hash_valid, output, 1: one-cycle pulse that marks a new hash_out.
REQ-010 Port hash_out, output, 256: updated chaining value, using the same word order as hash_in.

Function
REQ-011 The FSM SHALL have four states: IDLE, LOAD, ROUND and FINAL.
REQ-012 In IDLE, on start=1 with w_vector_complete=1, the block SHALL capture w_vector and hash_in into internal registers and go to LOAD.
REQ-013 In IDLE, start=1 with w_vector_complete=0 SHALL be ignored: the block stays in IDLE and captures nothing.
REQ-014 In LOAD, working registers a..h SHALL be set from the captured H0..H7, the round counter SHALL be cleared to 0, and the FSM SHALL go to ROUND.
REQ-015 In ROUND, each cycle SHALL execute one SHA-256 round using K[t] and captured word W[t], where t is the round counter, then increment t.
REQ-016 Round arithmetic SHALL be as follows:
- T1 = h + Sigma1(e) + Ch(e,f,g) + K[t] + W[t]
- T2 = Sigma0(a) + Maj(a,b,c)
- Register shift: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
REQ-017 All additions SHALL be modulo 2^32, with carries discarded.
REQ-018 Sigma0 SHALL be ROTR2 ^ ROTR13 ^ ROTR22, and Sigma1 SHALL be ROTR6 ^ ROTR11 ^ ROTR25; rotations, not shifts.
REQ-019 When t=W_LENGTH-1 completes, the FSM SHALL go to FINAL.
REQ-020 In FINAL, hash_out SHALL be loaded with {H0+a, ..., H7+h}, each sum mod 2^32.
REQ-021 hash_valid SHALL be 1 for exactly the FINAL-exit cycle, and the FSM SHALL then return to IDLE.
REQ-022 Latency: with start accepted at edge E0, hash_valid SHALL be high in the cycle after edge E0+W_LENGTH+2, which is E66 for the default.
REQ-023 busy SHALL be 1 in LOAD, ROUND and FINAL, and 0 in IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 Changes on w_vector or hash_in after capture SHALL NOT affect the block in progress.
REQ-026 hash_out SHALL hold its last value until the next FINAL.
REQ-027 Back-to-back operation: start may be accepted in the IDLE cycle immediately following the hash_valid pulse.
REQ-028 The round counter SHALL be 6 bits wide (sized to $clog2(W_LENGTH)) and SHALL NOT wrap past W_LENGTH-1.

Reset
REQ-029 reset_n=0 SHALL immediately force the FSM to IDLE and clear to 0: busy, hash_valid, hash_out, the round counter, a..h, and the captured registers.
REQ-030 reset_n asserted mid-block SHALL abort the block with no hash_valid pulse.
REQ-031 After reset_n deasserts, the first start SHALL be honoured on the next rising edge.

Structure
REQ-032 The 64 K constants, the state enumeration, and the Ch, Maj, Sigma0 and Sigma1 functions SHALL reside in shared package sha256_pkg, alongside the existing schedule logic's sigma functions.
REQ-033 One combinational sub-module, sha256_round, SHALL compute the next a..h from the current a..h, K[t] and W[t].
REQ-034 sha256_compress_rounds SHALL hold only the FSM, the counter, the capture registers and the final adder.
REQ-035 No multi-cycle paths are permitted; one round per clock.

Verification
REQ-036 "abc" block:
- Stimulus: fully expanded schedule of the padded "abc" block, hash_in = the standard IV (6a09e667 ... 5be0cd19), start pulse.
- Response: at E66, hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with hash_valid high for exactly one cycle.
REQ-037 Empty message:
- Stimulus: schedule of the padded empty message, with the IV.
- Response: hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-038 Capture and qualification:
- Start with w_vector_complete=0: busy stays 0 and there is no pulse.
- Start at cycle 10 of an active block: ignored; a single hash_valid pulse occurs at E66.
- w_vector corrupted after capture: the result is unchanged.
REQ-039 Reset mid-operation: reset_n pulsed low at round 30 returns all outputs to 0 with no hash_valid; a subsequent "abc" run gives the correct digest.
REQ-040 Two-block chaining:
- Block 1 is the first block of a 56-byte "abcdbcdecdefdefg..." message.
- Feed hash_out back as hash_in with block 2 in the IDLE cycle right after the pulse.
- Final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, FSM states and round/schedule functions
// Contents:
//   state_t        compression FSM states
//   work_t         working variables a..h (a in the top 32 bits, matching H0 order)
//   K, k_const     round constants
//   ch, maj, big_sigma0, big_sigma1   compression functions
//   small_sigma0, small_sigma1        message schedule functions
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    FINAL = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    return K[idx];
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Rotations are written as concatenations so no shifted-in zeros can sneak in.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_compress_rounds_if.sv
// rtl/sha256_compress_rounds_if.sv - request/response bundle of the compression block
// Signals:
//   start, w_vector_complete   block request and schedule-ready qualifier
//   w_vector                   expanded schedule, word i at [32i+31:32i]
//   hash_in, hash_out          chaining value, H0 at [255:224]
//   busy, hash_valid           activity flag and one-cycle result strobe
// master: schedule/controller side; slave: compression block.
interface sha256_compress_rounds_if #(
  parameter int W_LENGTH = 64
);
  logic                     start;
  logic                     w_vector_complete;
  logic [32*W_LENGTH-1:0]   w_vector;
  logic [255:0]             hash_in;
  logic                     busy;
  logic                     hash_valid;
  logic [255:0]             hash_out;

  modport master (
    output start, w_vector_complete, w_vector, hash_in,
    input  busy, hash_valid, hash_out
  );

  modport slave (
    input  start, w_vector_complete, w_vector, hash_in,
    output busy, hash_valid, hash_out
  );
endinterface

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 round
// Ports:
//   cur  working variables a..h before the round
//   k    round constant K[t]
//   w    schedule word W[t]
//   nxt  working variables after the round
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1    = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    t2    = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt.a = t1 + t2;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/sha256_compress_rounds.sv
// rtl/sha256_compress_rounds.sv - iterative SHA-256 compression, one round per clock
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of sha256_compress_rounds_if (start/schedule/chaining in,
//            busy/hash_valid/hash_out out)
module sha256_compress_rounds
  import sha256_pkg::*;
#(
  parameter int W_LENGTH = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  sha256_compress_rounds_if.slave    bus
);

  localparam int               CNT_W  = (W_LENGTH > 1) ? $clog2(W_LENGTH) : 1;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(W_LENGTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] t;
  logic [31:0]      w_mem [W_LENGTH];
  work_t            h_cap;
  work_t            work;
  work_t            work_nxt;
  logic             accept;

  // A request only counts once the producer reports a full schedule.
  assign accept = bus.start && bus.w_vector_complete;

  sha256_round u_round (
    .cur (work),
    .k   (k_const(6'(t))),
    .w   (w_mem[t]),
    .nxt (work_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b1;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (accept) begin
          state_nxt = LOAD;
        end
      end
      LOAD:    state_nxt = ROUND;
      ROUND: begin
        if (t == T_LAST) begin
          state_nxt = FINAL;
        end
      end
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < W_LENGTH; i++) begin
        w_mem[i] <= '0;
      end
      h_cap          <= '0;
      work           <= '0;
      t              <= '0;
      bus.hash_out   <= '0;
      bus.hash_valid <= 1'b0;
    end else begin
      bus.hash_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Private copies let the producer move on to the next block at once.
          if (accept) begin
            for (int i = 0; i < W_LENGTH; i++) begin
              w_mem[i] <= bus.w_vector[32*i +: 32];
            end
            h_cap <= bus.hash_in;
          end
        end
        LOAD: begin
          work <= h_cap;
          t    <= '0;
        end
        ROUND: begin
          work <= work_nxt;
          // Counter parks on the last index instead of wrapping.
          if (t != T_LAST) begin
            t <= t + CNT_W'(1);
          end
        end
        FINAL: begin
          bus.hash_out   <= {h_cap.a + work.a, h_cap.b + work.b,
                             h_cap.c + work.c, h_cap.d + work.d,
                             h_cap.e + work.e, h_cap.f + work.f,
                             h_cap.g + work.g, h_cap.h + work.h};
          bus.hash_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress_rounds.sv
// tb/tb_sha256_compress_rounds.sv - scoreboard bench for sha256_compress_rounds
module tb_sha256_compress_rounds;

  localparam int W_LENGTH = 64;
  localparam int LAT      = W_LENGTH + 2;

  localparam logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] CH1_BLK   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] CH2_BLK   = {480'h0, 32'h000001c0};

  typedef struct {
    logic [255:0] hash;
    int           cycle;
    bit           check_hash;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_compress_rounds_if #(.W_LENGTH(W_LENGTH)) bus ();

  sha256_compress_rounds #(.W_LENGTH(W_LENGTH)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, expd);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0]   w [64];
    logic [2047:0] v;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 64; i++) v[32*i +: 32] = w[i];
    return v;
  endfunction

  // Every pulse must be owed to an accepted start and arrive at the fixed latency.
  always @(negedge clk) begin
    if (reset_n && bus.hash_valid) begin
      pulses++;
      check("pulse_width", {prev_valid, bus.hash_valid}, 2'b01);
      check("busy_at_pulse", bus.busy, 1'b0);
      check("pulse_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        if (mon_e.check_hash) check("digest", bus.hash_out, mon_e.hash);
        check("latency", cyc, mon_e.cycle);
      end
    end
    prev_valid = bus.hash_valid;
  end

  task automatic launch(input logic [511:0] blk, input logic [255:0] hin,
                        input logic [255:0] expd, input bit chk);
    exp_t e;
    @(posedge clk); #1;
    bus.w_vector          = expand(blk);
    bus.hash_in           = hin;
    bus.w_vector_complete = 1'b1;
    bus.start             = 1'b1;
    e.hash = expd; e.cycle = cyc + 1 + LAT; e.check_hash = chk;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_after_start", bus.busy, 1'b1);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n = 0;
    while (pulses < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("pulse_count", pulses, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    exp_t e;
    bus.start = 1'b0; bus.w_vector_complete = 1'b0; bus.w_vector = '0; bus.hash_in = '0;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_valid", bus.hash_valid, 1'b0);
    check("reset_hash", bus.hash_out, '0);
    @(posedge clk); #1 reset_n = 1'b1;

    // "abc" and empty message
    base = pulses;
    launch(ABC_BLK, IV, ABC, 1'b1);
    wait_pulses(base + 1, 100);
    launch(EMPTY_BLK, IV, EMPTY, 1'b1);
    wait_pulses(base + 2, 100);

    // start without a complete schedule is ignored
    base = pulses;
    @(posedge clk); #1;
    bus.w_vector = expand(ABC_BLK); bus.w_vector_complete = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("incomplete_busy", bus.busy, 1'b0);
    end
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("incomplete_no_pulse", pulses, base);

    // start during an active block is dropped, not queued
    base = pulses;
    launch(ABC_BLK, IV, ABC, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    bus.w_vector = expand(EMPTY_BLK); bus.w_vector_complete = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_pulses(base + 1, 100);
    repeat (80) @(negedge clk);
    check("no_queued_start", pulses, base + 1);
    check("hash_out_hold", bus.hash_out, ABC);

    // inputs scrambled right after capture
    base = pulses;
    launch(ABC_BLK, IV, ABC, 1'b1);
    for (int i = 0; i < W_LENGTH; i++) bus.w_vector[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++) bus.hash_in[32*i +: 32] = $urandom;
    wait_pulses(base + 1, 100);

    // reset around round 30 aborts the block silently
    base = pulses;
    launch(EMPTY_BLK, IV, EMPTY, 1'b1);
    repeat (30) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_valid", bus.hash_valid, 1'b0);
    check("abort_hash", bus.hash_out, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_pulse", pulses, base);
    launch(ABC_BLK, IV, ABC, 1'b1);
    wait_pulses(base + 1, 100);

    // two-block chaining, second start in the cycle right after the pulse
    base = pulses;
    launch(CH1_BLK, IV, '0, 1'b0);
    n = 0;
    while (!bus.hash_valid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("chain_block1_pulse", bus.hash_valid, 1'b1);
    bus.hash_in  = bus.hash_out;
    bus.w_vector = expand(CH2_BLK);
    bus.w_vector_complete = 1'b1;
    bus.start    = 1'b1;
    e.hash = TWO; e.cycle = cyc + 1 + LAT; e.check_hash = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    check("chain_busy", bus.busy, 1'b1);
    wait_pulses(base + 2, 100);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
